// File: rtl/stepper_arbiter_if.sv
// Bundle between the arbiter, its requesters and the shared stepper driver.
// The slave view belongs to the arbiter. The master view is the environment:
// the requesters that drive req/req_dir and the driver that returns motor_step.
interface stepper_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0] req;        // level request, held until ack
   logic [NUM_REQ-1:0] req_dir;    // direction, sampled at grant
   logic [NUM_REQ-1:0] grant;      // one-hot owner, 0 when idle
   logic [NUM_REQ-1:0] ack;        // one-cycle completion pulse
   logic               error;      // coincident with ack on a timed-out move
   logic               busy;       // arbiter not idle
   logic               stp_start;  // to driver start
   logic               stp_dir;    // to driver dir
   logic               stp_step;   // driver motor_step

   modport master (
      output req, req_dir, stp_step,
      input  grant, ack, error, busy, stp_start, stp_dir
   );

   modport slave (
      input  req, req_dir, stp_step,
      output grant, ack, error, busy, stp_start, stp_dir
   );
endinterface

// File: rtl/stepper_arbiter.sv
// Round-robin sharing of one stepper driver between NUM_REQ requesters.
// A granted move raises stp_start, counts driver step edges until NUM_STEPS
// arrive (or a watchdog expires), holds start low for GAP_CYCLES so the driver
// returns to idle, then pulses ack (and error on a watchdog abort) to the owner.
module stepper_arbiter #(
   parameter int          NUM_REQ        = 4,
   parameter logic [11:0] NUM_STEPS      = 12'd400,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
   parameter logic [7:0]  GAP_CYCLES     = 8'd4
) (
   input logic              clk,
   input logic              reset,
   stepper_arbiter_if.slave bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_e;

   state_e             state,      state_nxt;
   logic [NUM_REQ-1:0] grant_q,    grant_nxt;
   logic [NUM_REQ-1:0] ack_q,      ack_nxt;
   logic               error_q,    error_nxt;
   logic               start_q,    start_nxt;
   logic               dir_q,      dir_nxt;
   logic [11:0]        step_cnt,   step_cnt_nxt;
   logic [19:0]        timer,      timer_nxt;
   logic [7:0]         gap_cnt,    gap_cnt_nxt;
   logic               fail,       fail_nxt;
   logic [IDX_W-1:0]   last_grant, last_grant_nxt;
   logic [IDX_W-1:0]   owner,      owner_nxt;
   logic               step_d;

   logic               step_edge;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   cand;

   // Rising edge of the driver's motor_step; only S_RUN pays attention to it.
   assign step_edge = bus.stp_step & ~step_d;

   // Round-robin search beginning just after the previous owner, with wrap.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
         if (!pick_valid && bus.req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic for the move sequencer.
   // NOTE: every signal gets its hold/default value before the case, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_q;
      ack_nxt        = '0;
      error_nxt      = 1'b0;
      start_nxt      = start_q;
      dir_nxt        = dir_q;
      step_cnt_nxt   = step_cnt;
      timer_nxt      = timer;
      gap_cnt_nxt    = gap_cnt;
      fail_nxt       = fail;
      last_grant_nxt = last_grant;
      owner_nxt      = owner;

      case (state)
         S_IDLE: begin
            if (pick_valid) begin
               grant_nxt    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
               owner_nxt    = pick_idx;
               dir_nxt      = bus.req_dir[pick_idx];
               start_nxt    = 1'b1;
               step_cnt_nxt = '0;
               timer_nxt    = '0;
               state_nxt    = S_RUN;
            end
         end

         S_RUN: begin
            timer_nxt = timer + 20'd1;
            // The final step takes precedence over a simultaneous watchdog expiry.
            if (step_edge && (step_cnt == NUM_STEPS - 12'd1)) begin
               start_nxt   = 1'b0;
               gap_cnt_nxt = '0;
               state_nxt   = S_GAP;
            end else begin
               if (step_edge) begin
                  step_cnt_nxt = step_cnt + 12'd1;
               end
               if (timer == TIMEOUT_CYCLES - 20'd1) begin
                  start_nxt   = 1'b0;
                  fail_nxt    = 1'b1;
                  gap_cnt_nxt = '0;
                  state_nxt   = S_GAP;
               end
            end
         end

         S_GAP: begin
            // Start is already low; step edges seen here belong to the driver
            // winding down and are deliberately ignored.
            if (gap_cnt == GAP_CYCLES - 8'd1) begin
               ack_nxt        = grant_q;
               error_nxt      = fail;
               grant_nxt      = '0;
               last_grant_nxt = owner;
               fail_nxt       = 1'b0;
               state_nxt      = S_IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + 8'd1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers, cleared by the synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         grant_q    <= '0;
         ack_q      <= '0;
         error_q    <= 1'b0;
         start_q    <= 1'b0;
         dir_q      <= 1'b0;
         step_cnt   <= '0;
         timer      <= '0;
         gap_cnt    <= '0;
         fail       <= 1'b0;
         last_grant <= IDX_W'(NUM_REQ - 1);
         owner      <= '0;
         step_d     <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         ack_q      <= ack_nxt;
         error_q    <= error_nxt;
         start_q    <= start_nxt;
         dir_q      <= dir_nxt;
         step_cnt   <= step_cnt_nxt;
         timer      <= timer_nxt;
         gap_cnt    <= gap_cnt_nxt;
         fail       <= fail_nxt;
         last_grant <= last_grant_nxt;
         owner      <= owner_nxt;
         step_d     <= bus.stp_step;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.ack       = ack_q;
   assign bus.error     = error_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.stp_start = start_q;
   assign bus.stp_dir   = dir_q;

endmodule

// File: tb/tb_stepper_arbiter.sv
// Bench for stepper_arbiter: a stepper driver model (CLK_DIVIDE=3) with
// selectable behaviour, requesters that drop req once acked, and a scoreboard
// of expected completions derived from the round-robin rule.
module tb_stepper_arbiter;

   localparam int          NUM_REQ    = 4;
   localparam logic [11:0] NUM_STEPS  = 12'd4;
   localparam logic [19:0] TIMEOUT    = 20'd50;
   localparam logic [7:0]  GAP        = 8'd4;
   localparam int          CLK_DIVIDE = 3;

   typedef enum int {DRV_NORMAL, DRV_GAPNOISE, DRV_STALL, DRV_LATE} drv_mode_e;

   typedef struct {
      logic [3:0] onehot;
      logic       dir;
      logic       err;
      drv_mode_e  mode;
   } exp_t;

   logic      clk = 1'b0;
   logic      reset;
   int        cyc = 0;
   int        checks;
   int        errors;
   exp_t      sb[$];
   drv_mode_e drv_mode;
   int        drv_pulses;
   logic [3:0] keep;
   logic      scramble;
   int        model_last;

   stepper_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   stepper_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .NUM_STEPS      (NUM_STEPS),
      .TIMEOUT_CYCLES (TIMEOUT),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // First requester in mask after 'last', wrapping around.
   function automatic int rr_pick(input logic [3:0] mask, input int last);
      for (int off = 1; off <= NUM_REQ; off++) begin
         if (mask[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
      end
      return -1;
   endfunction

   // Push the completions expected when every bit of mask is pending and each
   // requester leaves once served; returns the first owner.
   task automatic expect_order(input logic [3:0] mask, input logic [3:0] dirs,
                               input drv_mode_e mode, output int first);
      logic [3:0] m;
      int         l;
      int         idx;
      exp_t       e;
      m     = mask;
      l     = model_last;
      first = -1;
      while (m != 4'b0000) begin
         idx      = rr_pick(m, l);
         e.onehot = 4'(32'd1 << idx);
         e.dir    = dirs[idx];
         e.err    = (mode == DRV_STALL);
         e.mode   = mode;
         sb.push_back(e);
         if (first < 0) first = idx;
         m[idx] = 1'b0;
         l      = idx;
      end
      model_last = l;
   endtask

   // One cycle of requester behaviour, applied on the falling edge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.ack[i] && !keep[i]) bus.req[i] = 1'b0;
         if (scramble && bus.grant[i]) begin
            if ($urandom_range(0, 3) == 0) bus.req_dir[i] = ~bus.req_dir[i];
            if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.busy) && n < budget) begin
         tick();
         n++;
      end
      check("drain_scoreboard_empty", sb.size(), 0);
   endtask

   task automatic issue(input logic [3:0] mask, input logic [3:0] dirs, input drv_mode_e mode);
      int first;
      drv_mode    = mode;
      bus.req_dir = dirs;
      expect_order(mask, dirs, mode, first);
      bus.req = bus.req | mask;
      tick();
      check("grant_latency", bus.grant, 4'(32'd1 << first));
      check("start_at_grant", bus.stp_start, 1);
      check("dir_at_grant", bus.stp_dir, dirs[first]);
      drain(500);
   endtask

   task automatic reset_dut();
      reset   = 1'b1;
      bus.req = '0;
      tick();
      tick();
      reset      = 1'b0;
      model_last = NUM_REQ - 1;
   endtask

   // Driver model: steps every CLK_DIVIDE cycles while start is high.
   initial begin : driver
      int   k;
      int   f;
      logic run;
      logic nxt;
      run          = 1'b0;
      k            = 0;
      f            = 99;
      drv_pulses   = 0;
      bus.stp_step = 1'b0;
      forever begin
         @(negedge clk);
         nxt = 1'b0;
         if (bus.stp_start) begin
            if (!run) begin
               run        = 1'b1;
               k          = 0;
               drv_pulses = 0;
            end else begin
               k++;
            end
            f = 99;
            case (drv_mode)
               DRV_NORMAL, DRV_GAPNOISE:
                  nxt = (k >= 1 && k <= CLK_DIVIDE * int'(NUM_STEPS) && (k % CLK_DIVIDE) != 0);
               DRV_LATE:
                  nxt = (k == 10 || k == 20 || k == 30 || k == int'(TIMEOUT) - 1);
               default:
                  nxt = 1'b0;
            endcase
         end else begin
            if (run) f = 0;
            else if (f < 99) f++;
            run = 1'b0;
            if (drv_mode == DRV_GAPNOISE) nxt = (f == 1 || f == 3);
         end
         if (nxt && !bus.stp_step && bus.stp_start) drv_pulses++;
         bus.stp_step = nxt;
      end
   end

   // Monitor: pops the scoreboard on every ack and checks the whole move.
   initial begin : monitor
      logic [3:0] prev_grant;
      logic       prev_start;
      int         grant_cyc;
      int         fall_cyc;
      int         pulses_at_fall;
      logic       dir_g;
      logic       dir_ok;
      logic [3:0] own;
      exp_t       e;
      prev_grant     = '0;
      prev_start     = 1'b0;
      grant_cyc      = 0;
      fall_cyc       = 0;
      pulses_at_fall = 0;
      dir_g          = 1'b0;
      dir_ok         = 1'b1;
      own            = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (prev_grant == 4'b0000 && bus.grant != 4'b0000) begin
               grant_cyc = cyc;
               dir_g     = bus.stp_dir;
               dir_ok    = 1'b1;
               own       = bus.grant;
            end else if (bus.grant != 4'b0000 &&
                         (bus.stp_dir != dir_g || bus.grant != own)) begin
               dir_ok = 1'b0;
            end
            if (prev_start && !bus.stp_start) begin
               fall_cyc       = cyc;
               pulses_at_fall = drv_pulses;
            end
            if (bus.ack != 4'b0000) begin
               if (sb.size() == 0) begin
                  check("unexpected_ack", bus.ack, 0);
               end else begin
                  e = sb.pop_front();
                  check("ack_owner", bus.ack, e.onehot);
                  check("ack_error", bus.error, e.err);
                  check("ack_busy_low", bus.busy, 0);
                  check("owner_dir", dir_g, e.dir);
                  check("grant_dir_stable", dir_ok, 1);
                  check("gap_cycles", cyc - fall_cyc, GAP);
                  if (e.mode == DRV_STALL || e.mode == DRV_LATE)
                     check("run_cycles", fall_cyc - grant_cyc, TIMEOUT);
                  if (e.mode != DRV_STALL)
                     check("steps_at_fall", pulses_at_fall, NUM_STEPS);
               end
            end else if (bus.error) begin
               check("error_without_ack", bus.error, 0);
            end
         end
         prev_grant = bus.grant;
         prev_start = bus.stp_start;
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin : stimulus
      int n;
      int first;
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      bus.req     = '0;
      bus.req_dir = '0;
      keep        = '0;
      scramble    = 1'b0;
      drv_mode    = DRV_NORMAL;
      model_last  = NUM_REQ - 1;

      repeat (3) tick();
      check("rst_grant", bus.grant, 0);
      check("rst_ack", bus.ack, 0);
      check("rst_error", bus.error, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_stp_start", bus.stp_start, 0);
      check("rst_stp_dir", bus.stp_dir, 0);
      reset = 1'b0;
      tick();
      check("idle_busy", bus.busy, 0);

      // Single move, direction 1.
      issue(4'b0001, 4'b0001, DRV_NORMAL);

      // All four requesting from reset: served 0,1,2,3.
      reset_dut();
      issue(4'b1111, 4'b0101, DRV_NORMAL);

      // Re-request: req[0] stays up after its ack while req[2] rises.
      drv_mode    = DRV_NORMAL;
      bus.req_dir = 4'b0001;
      keep        = 4'b0001;
      expect_order(4'b0001, 4'b0001, DRV_NORMAL, first);
      bus.req[0] = 1'b1;
      n = 0;
      while (!bus.ack[0] && n < 200) begin
         tick();
         n++;
      end
      check("rereq_first_ack", bus.ack, 4'b0001);
      bus.req[2] = 1'b1;
      keep       = '0;
      expect_order(4'b0101, 4'b0001, DRV_NORMAL, first);
      drain(500);

      // Watchdog abort, then final step exactly on the last watchdog cycle,
      // then extra step pulses while start is low.
      issue(4'b0001, 4'b0000, DRV_STALL);
      issue(4'b0010, 4'b0010, DRV_LATE);
      issue(4'b0100, 4'b0100, DRV_GAPNOISE);

      // Reset in the middle of a move.
      drv_mode    = DRV_NORMAL;
      bus.req_dir = 4'b0000;
      bus.req     = 4'b0001;
      tick();
      n = 0;
      while (drv_pulses < 2 && n < 100) begin
         tick();
         n++;
      end
      check("midmove_two_steps", (drv_pulses >= 2), 1);
      reset   = 1'b1;
      bus.req = '0;
      tick();
      check("midmove_rst_start", bus.stp_start, 0);
      check("midmove_rst_grant", bus.grant, 0);
      check("midmove_rst_busy", bus.busy, 0);
      reset      = 1'b0;
      model_last = NUM_REQ - 1;
      issue(4'b0010, 4'b0010, DRV_NORMAL);

      // Randomised phases with owner-side noise on req/req_dir.
      scramble = 1'b1;
      for (int p = 0; p < 25; p++) begin
         int        r;
         drv_mode_e m;
         r = $urandom_range(0, 9);
         m = (r == 0) ? DRV_STALL : (r == 1) ? DRV_LATE : (r == 2) ? DRV_GAPNOISE : DRV_NORMAL;
         issue(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), m);
      end
      scramble = 1'b0;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
